// File: rtl/uart_rx.sv
// uart_rx -- asynchronous serial receiver (8N1 / 8E1 / 8O1).
//
// Receives start bit, 8 data bits LSB first, an optional parity bit and one
// stop bit. Bits are sampled at mid-bit by a clock-count bit timer. Each
// accepted byte is held in rx_data with a ready/ack handshake and per-byte
// framing and parity flags. A sticky overrun flag records frames that
// completed while the previous byte was still unconsumed.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   PARITY_EN     1 = parity bit present and checked, 0 = no parity bit
//   PARITY_ODD    0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   RXD            serial input, asynchronous to clk, idle high
//   rx_ack         host consumes the held byte
//   rx_ready       a received byte is held in rx_data
//   rx_data        last accepted byte
//   framing_error  stop bit was sampled low for the byte in rx_data
//   parity_error   parity mismatch for the byte in rx_data
//   overrun_error  a frame completed while rx_ready was high (sticky until ack)
//   busy           receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RXD,
  input  logic       rx_ack,
  output logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       framing_error,
  output logic       parity_error,
  output logic       overrun_error,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Two-flop synchronizer; only rxd_s is used downstream.
  logic rxd_m_reg;
  logic rxd_s;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic          par_bad_reg, par_bad_next;
  // Set when a frame ends with the line low (break / framing error): the
  // line must be seen high before another start bit is accepted.
  logic          wait_high_reg, wait_high_next;

  logic          rx_ready_reg, rx_ready_next;
  logic [7:0]    rx_data_reg, rx_data_next;
  logic          fe_reg, fe_next;
  logic          pe_reg, pe_next;
  logic          oe_reg, oe_next;

  logic          complete;
  logic          stop_low;
  logic          par_expected;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m_reg <= 1'b1;
      rxd_s     <= 1'b1;
    end else begin
      rxd_m_reg <= RXD;
      rxd_s     <= rxd_m_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shreg_reg     <= '0;
      par_bad_reg   <= 1'b0;
      wait_high_reg <= 1'b0;
      rx_ready_reg  <= 1'b0;
      rx_data_reg   <= 8'h00;
      fe_reg        <= 1'b0;
      pe_reg        <= 1'b0;
      oe_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shreg_reg     <= shreg_next;
      par_bad_reg   <= par_bad_next;
      wait_high_reg <= wait_high_next;
      rx_ready_reg  <= rx_ready_next;
      rx_data_reg   <= rx_data_next;
      fe_reg        <= fe_next;
      pe_reg        <= pe_next;
      oe_reg        <= oe_next;
    end
  end

  // Parity bit value a correct transmitter sends for the received byte.
  assign par_expected = PARITY_ODD ? ~(^shreg_reg) : (^shreg_reg);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    shreg_next     = shreg_reg;
    par_bad_next   = par_bad_reg;
    wait_high_next = wait_high_reg;
    complete       = 1'b0;
    stop_low       = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (wait_high_reg) begin
          if (rxd_s) begin
            wait_high_next = 1'b0;
          end
        end else if (!rxd_s) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (rxd_s) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
            par_bad_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next                = '0;
          shreg_next[bit_idx_reg] = rxd_s;
          if (bit_idx_reg == 3'd7) begin
            state_next = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          par_bad_next = (rxd_s != par_expected);
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          // Frame ends at mid stop bit so a following start edge is not missed.
          cnt_next       = '0;
          complete       = 1'b1;
          stop_low       = !rxd_s;
          wait_high_next = !rxd_s;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Host handshake and status flags.
  always_comb begin
    rx_ready_next = rx_ready_reg;
    rx_data_next  = rx_data_reg;
    fe_next       = fe_reg;
    pe_next       = pe_reg;
    oe_next       = oe_reg;

    if (complete) begin
      if (!rx_ready_reg || rx_ack) begin
        // Slot is free (or being freed this cycle): accept the new byte.
        rx_data_next  = shreg_reg;
        rx_ready_next = 1'b1;
        fe_next       = stop_low;
        pe_next       = PARITY_EN ? par_bad_reg : 1'b0;
        oe_next       = 1'b0;
      end else begin
        oe_next = 1'b1;
      end
    end else if (rx_ack && rx_ready_reg) begin
      rx_ready_next = 1'b0;
      fe_next       = 1'b0;
      pe_next       = 1'b0;
      oe_next       = 1'b0;
    end
  end

  assign rx_ready      = rx_ready_reg;
  assign rx_data       = rx_data_reg;
  assign framing_error = fe_reg;
  assign parity_error  = pe_reg;
  assign overrun_error = oe_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
//
// Three receivers share clk/rst: index 0 = even parity, 1 = no parity,
// 2 = odd parity, all with 16 clocks per bit. Frames are built bit by bit
// from the frame format; expectations come from plain rules (parity of the
// byte, stop bit value, latency formula, handshake rules).
module tb_uart_rx;

  localparam int C = 16;

  logic       clk;
  logic       rst;
  logic       rxd   [3];
  logic       ack   [3];
  logic       ready [3];
  logic [7:0] data  [3];
  logic       fe    [3];
  logic       pe    [3];
  logic       oe    [3];
  logic       busy  [3];

  int total;
  int bad;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      uart_rx #(
        .CLKS_PER_BIT(C),
        .PARITY_EN   (gi != 1),
        .PARITY_ODD  (gi == 2)
      ) dut (
        .clk          (clk),
        .rst          (rst),
        .RXD          (rxd[gi]),
        .rx_ack       (ack[gi]),
        .rx_ready     (ready[gi]),
        .rx_data      (data[gi]),
        .framing_error(fe[gi]),
        .parity_error (pe[gi]),
        .overrun_error(oe[gi]),
        .busy         (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Parity bit a correct transmitter sends for byte d on receiver k.
  function automatic logic good_par(input int k, input logic [7:0] d);
    return (k == 2) ? ~(^d) : (^d);
  endfunction

  task automatic drive_bit(input int k, input logic v);
    rxd[k] = v;
    repeat (C) @(negedge clk);
  endtask

  // Call at a negedge; returns at a negedge with the line idle high.
  task automatic send_frame(input int k, input logic [7:0] d, input logic par,
                            input logic stp, input int hold_low);
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (k != 1) drive_bit(k, par);
    drive_bit(k, stp);
    if (hold_low > 0) begin
      rxd[k] = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    rxd[k] = 1'b1;
  endtask

  task automatic do_ack(input int k);
    ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({ready[k], data[k], fe[k], pe[k], oe[k], busy[k]} !== 13'h0) begin
        bad++;
        $display("FAIL reset_state k=%0d got ready=%b data=%h fe=%b pe=%b oe=%b busy=%b expected all 0",
                 k, ready[k], data[k], fe[k], pe[k], oe[k], busy[k]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset: checked 3 receivers");
  endtask

  task automatic test_latency();
    int cyc;
    cyc = -1;
    fork
      send_frame(0, 8'hA5, good_par(0, 8'hA5), 1'b1, 0);
      begin
        for (int i = 1; i <= 400 && cyc < 0; i++) begin
          @(posedge clk);
          #1;
          if (ready[0]) cyc = i;
        end
      end
    join
    @(negedge clk);
    total++;
    if (cyc != 3 + C / 2 + 10 * C) begin
      bad++;
      $display("FAIL latency got=%0d expected=%0d", cyc, 3 + C / 2 + 10 * C);
    end
    total++;
    if (data[0] !== 8'hA5 || {fe[0], pe[0], oe[0]} !== 3'b000) begin
      bad++;
      $display("FAIL latency_data got data=%h flags=%b%b%b expected A5 000", data[0], fe[0], pe[0], oe[0]);
    end
    do_ack(0);
    total++;
    if (ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL ack_clear got ready=%b expected 0", ready[0]);
    end
    $display("latency: frame A5 ready after %0d cycles", cyc);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [$];
    int w;
    q = '{8'h3C, 8'hFF};
    fork
      begin
        send_frame(0, 8'h3C, good_par(0, 8'h3C), 1'b1, 0);
        send_frame(0, 8'hFF, good_par(0, 8'hFF), 1'b1, 0);
      end
      begin
        for (int n = 0; n < 2; n++) begin
          w = 0;
          while (ready[0] !== 1'b1 && w < 600) begin
            @(negedge clk);
            w++;
          end
          total++;
          if (ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_timeout n=%0d got ready=%b expected 1", n, ready[0]);
          end else begin
            if (data[0] !== q[n] || {fe[0], pe[0], oe[0]} !== 3'b000) begin
              bad++;
              $display("FAIL b2b_data n=%0d got data=%h flags=%b%b%b expected %h 000",
                       n, data[0], fe[0], pe[0], oe[0], q[n]);
            end
            $display("b2b: frame %0d data=%h", n, data[0]);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            do_ack(0);
            total++;
            if (ready[0] !== 1'b0) begin
              bad++;
              $display("FAIL b2b_ack n=%0d got ready=%b expected 0", n, ready[0]);
            end
          end
        end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_glitch();
    int w;
    rxd[0] = 1'b0;
    repeat (5) @(negedge clk);
    rxd[0] = 1'b1;
    w = 0;
    while (busy[0] !== 1'b0 && w < 8) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy got busy=%b expected 0", busy[0]);
    end
    repeat (2 * C) @(negedge clk);
    total++;
    if (ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL glitch_ready got ready=%b expected 0", ready[0]);
    end
    send_frame(0, 8'h81, good_par(0, 8'h81), 1'b1, 0);
    total++;
    if (ready[0] !== 1'b1 || data[0] !== 8'h81 || {fe[0], pe[0], oe[0]} !== 3'b000) begin
      bad++;
      $display("FAIL glitch_after got ready=%b data=%h flags=%b%b%b expected 1 81 000",
               ready[0], data[0], fe[0], pe[0], oe[0]);
    end
    do_ack(0);
    $display("glitch: 5-cycle pulse ignored, then data=81");
  endtask

  task automatic test_errors();
    // Bad parity.
    send_frame(0, 8'hA5, ~good_par(0, 8'hA5), 1'b1, 0);
    total++;
    if (ready[0] !== 1'b1 || data[0] !== 8'hA5 || pe[0] !== 1'b1 || fe[0] !== 1'b0) begin
      bad++;
      $display("FAIL parity_err got ready=%b data=%h pe=%b fe=%b expected 1 A5 1 0",
               ready[0], data[0], pe[0], fe[0]);
    end
    do_ack(0);
    total++;
    if ({ready[0], fe[0], pe[0], oe[0]} !== 4'b0000) begin
      bad++;
      $display("FAIL parity_ack got ready/fe/pe/oe=%b%b%b%b expected 0000", ready[0], fe[0], pe[0], oe[0]);
    end
    // Stop bit low followed by a break: no second frame may appear.
    send_frame(0, 8'h5A, good_par(0, 8'h5A), 1'b0, 2 * C);
    repeat (2 * C) @(negedge clk);
    total++;
    if (ready[0] !== 1'b1 || data[0] !== 8'h5A || fe[0] !== 1'b1 || pe[0] !== 1'b0 || oe[0] !== 1'b0) begin
      bad++;
      $display("FAIL framing_err got ready=%b data=%h fe=%b pe=%b oe=%b expected 1 5A 1 0 0",
               ready[0], data[0], fe[0], pe[0], oe[0]);
    end
    do_ack(0);
    total++;
    if (fe[0] !== 1'b0) begin
      bad++;
      $display("FAIL framing_ack got fe=%b expected 0", fe[0]);
    end
    // Same frame without parity.
    send_frame(1, 8'h5A, 1'b0, 1'b0, 0);
    total++;
    if (ready[1] !== 1'b1 || data[1] !== 8'h5A || fe[1] !== 1'b1 || pe[1] !== 1'b0) begin
      bad++;
      $display("FAIL noparity_err got ready=%b data=%h fe=%b pe=%b expected 1 5A 1 0",
               ready[1], data[1], fe[1], pe[1]);
    end
    do_ack(1);
    $display("errors: parity, framing+break, no-parity framing done");
  endtask

  task automatic test_overrun();
    send_frame(0, 8'h11, good_par(0, 8'h11), 1'b1, 0);
    send_frame(0, 8'h22, good_par(0, 8'h22), 1'b1, 0);
    total++;
    if (ready[0] !== 1'b1 || data[0] !== 8'h11 || oe[0] !== 1'b1 || {fe[0], pe[0]} !== 2'b00) begin
      bad++;
      $display("FAIL overrun got ready=%b data=%h oe=%b fe=%b pe=%b expected 1 11 1 0 0",
               ready[0], data[0], oe[0], fe[0], pe[0]);
    end
    do_ack(0);
    total++;
    if ({ready[0], fe[0], pe[0], oe[0]} !== 4'b0000) begin
      bad++;
      $display("FAIL overrun_ack got ready/fe/pe/oe=%b%b%b%b expected 0000", ready[0], fe[0], pe[0], oe[0]);
    end
    // Ack arriving in the completion cycle of the next byte.
    send_frame(0, 8'h33, good_par(0, 8'h33), 1'b1, 0);
    fork
      send_frame(0, 8'h44, good_par(0, 8'h44), 1'b1, 0);
      begin
        repeat (2 + C / 2 + 10 * C) @(negedge clk);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        total++;
        if (ready[0] !== 1'b1 || data[0] !== 8'h44 || oe[0] !== 1'b0) begin
          bad++;
          $display("FAIL ack_on_complete got ready=%b data=%h oe=%b expected 1 44 0",
                   ready[0], data[0], oe[0]);
        end
      end
    join
    @(negedge clk);
    do_ack(0);
    $display("overrun: 11 held, 22 dropped; 44 loaded on coincident ack");
  endtask

  task automatic test_reset_mid();
    send_frame(0, 8'h6E, good_par(0, 8'h6E), 1'b1, 0);
    // F8 keeps the line high from data bit 3 onward, so nothing restarts after reset.
    fork
      send_frame(0, 8'hF8, good_par(0, 8'hF8), 1'b1, 0);
      begin
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({ready[0], data[0], fe[0], pe[0], oe[0], busy[0]} !== 13'h0) begin
          bad++;
          $display("FAIL reset_mid got ready=%b data=%h fe=%b pe=%b oe=%b busy=%b expected all 0",
                   ready[0], data[0], fe[0], pe[0], oe[0], busy[0]);
        end
      end
    join
    repeat (C) @(negedge clk);
    total++;
    if (ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_quiet got ready=%b busy=%b expected 0 0", ready[0], busy[0]);
    end
    send_frame(0, 8'hC3, good_par(0, 8'hC3), 1'b1, 0);
    total++;
    if (ready[0] !== 1'b1 || data[0] !== 8'hC3 || {fe[0], pe[0], oe[0]} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_next got ready=%b data=%h flags=%b%b%b expected 1 C3 000",
               ready[0], data[0], fe[0], pe[0], oe[0]);
    end
    do_ack(0);
    $display("reset_mid: frame abandoned, then data=C3");
  endtask

  task automatic test_random();
    int         k;
    logic [7:0] d;
    logic       par_ok;
    logic       stp;
    logic       exp_pe;
    for (int n = 0; n < 24; n++) begin
      k      = $urandom_range(0, 2);
      d      = 8'($urandom);
      par_ok = ($urandom_range(0, 3) != 0);
      stp    = ($urandom_range(0, 3) != 0);
      exp_pe = (k != 1) && !par_ok;
      repeat ($urandom_range(0, 10)) @(negedge clk);
      send_frame(k, d, par_ok ? good_par(k, d) : ~good_par(k, d), stp,
                 stp ? 0 : $urandom_range(0, 20));
      $display("random: n=%0d k=%0d byte=%h par_ok=%b stop=%b -> data=%h fe=%b pe=%b",
               n, k, d, par_ok, stp, data[k], fe[k], pe[k]);
      total++;
      if (ready[k] !== 1'b1 || data[k] !== d || fe[k] !== !stp || pe[k] !== exp_pe || oe[k] !== 1'b0) begin
        bad++;
        $display("FAIL random n=%0d k=%0d got ready=%b data=%h fe=%b pe=%b oe=%b expected 1 %h %b %b 0",
                 n, k, ready[k], data[k], fe[k], pe[k], oe[k], d, !stp, exp_pe);
      end
      do_ack(k);
      total++;
      if ({ready[k], fe[k], pe[k], oe[k]} !== 4'b0000) begin
        bad++;
        $display("FAIL random_ack n=%0d got ready/fe/pe/oe=%b%b%b%b expected 0000",
                 n, ready[k], fe[k], pe[k], oe[k]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rxd[k] = 1'b1;
      ack[k] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_glitch();
    test_errors();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
